// File: rtl/rggen_rr_arbiter_if.sv
// Request/grant bundle between the requesters, the shared resource and rggen_rr_arbiter.
// The arbiter takes the slave modport; requester/resource side takes master.
interface rggen_rr_arbiter_if #(
   parameter int REQUESTERS = 2
);
   localparam int IW = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;

   logic [REQUESTERS-1:0] i_request;
   logic                  i_done;
   logic [REQUESTERS-1:0] o_grant;
   logic [IW-1:0]         o_grant_index;
   logic                  o_busy;
   logic                  o_timeout;

   modport master (
      output i_request, i_done,
      input  o_grant, o_grant_index, o_busy, o_timeout
   );

   modport slave (
      input  i_request, i_done,
      output o_grant, o_grant_index, o_busy, o_timeout
   );
endinterface

// File: rtl/rggen_rr_arbiter.sv
// Round-robin arbiter with registered one-hot grant held until i_done.
// Optional forced release after TIMEOUT busy cycles when RGGEN_RR_ARBITER_TIMEOUT_EN is defined.
module rggen_rr_arbiter #(
   parameter int REQUESTERS = 2,
   parameter int TIMEOUT    = 255
) (
   input logic               i_clk,
   input logic               i_rst_n,
   rggen_rr_arbiter_if.slave arb_if
);
   localparam int          IW = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
   localparam int unsigned NR = REQUESTERS;

   if (REQUESTERS < 1 || REQUESTERS > 32 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_param_check
      $error("rggen_rr_arbiter: parameter out of range");
   end

   typedef enum logic {IDLE, BUSY} state_e;

   state_e                state_q, state_d;
   logic [IW-1:0]         ptr_q, ptr_d;
   logic [IW-1:0]         index_q, index_d;
   logic [REQUESTERS-1:0] grant_q, grant_d;
   logic                  timeout_q, timeout_d;

   logic                  found;
   logic [IW-1:0]         winner;
   logic [IW-1:0]         cand;
   logic [IW-1:0]         next_ptr;
   logic                  expire;
   int unsigned           idx;

`ifdef RGGEN_RR_ARBITER_TIMEOUT_EN
   logic [15:0] count_q, count_d;
   assign expire = (count_q == 16'(TIMEOUT));
`else
   assign expire = 1'b0;
`endif

   // Scan from the pointer upward with wrap; first set request wins.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      idx    = 0;
      cand   = '0;
      for (int unsigned i = 0; i < NR; i++) begin
         idx = 32'(ptr_q) + i;
         if (idx >= NR) idx = idx - NR;
         cand = IW'(idx);
         if (!found && arb_if.i_request[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
   end

   assign next_ptr = (index_q == IW'(REQUESTERS - 1)) ? '0 : index_q + 1'b1;

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      index_d   = index_q;
      grant_d   = grant_q;
      timeout_d = 1'b0;
`ifdef RGGEN_RR_ARBITER_TIMEOUT_EN
      count_d   = count_q;
`endif
      case (state_q)
         IDLE: begin
            if (found) begin
               state_d         = BUSY;
               grant_d         = '0;
               grant_d[winner] = 1'b1;
               index_d         = winner;
`ifdef RGGEN_RR_ARBITER_TIMEOUT_EN
               count_d         = '0;
`endif
            end
         end
         BUSY: begin
            if (arb_if.i_done || expire) begin
               state_d   = IDLE;
               grant_d   = '0;
               index_d   = '0;
               ptr_d     = next_ptr;
               timeout_d = expire && !arb_if.i_done;
            end
`ifdef RGGEN_RR_ARBITER_TIMEOUT_EN
            else begin
               count_d = count_q + 16'd1;
            end
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= IDLE;
         ptr_q     <= '0;
         index_q   <= '0;
         grant_q   <= '0;
         timeout_q <= 1'b0;
`ifdef RGGEN_RR_ARBITER_TIMEOUT_EN
         count_q   <= '0;
`endif
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         index_q   <= index_d;
         grant_q   <= grant_d;
         timeout_q <= timeout_d;
`ifdef RGGEN_RR_ARBITER_TIMEOUT_EN
         count_q   <= count_d;
`endif
      end
   end

   assign arb_if.o_grant       = grant_q;
   assign arb_if.o_grant_index = index_q;
   assign arb_if.o_busy        = (state_q == BUSY);
   assign arb_if.o_timeout     = timeout_q;
endmodule

// File: tb/tb_rggen_rr_arbiter.sv
// Directed bench for rggen_rr_arbiter: fairness, wrap, hold, timeout, async reset, ignored done.
module tb_rggen_rr_arbiter;
   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   rggen_rr_arbiter_if #(.REQUESTERS(4)) arb_if ();

   rggen_rr_arbiter #(
      .REQUESTERS (4),
      .TIMEOUT    (8)
   ) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .arb_if  (arb_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_arb(input string tag, input logic [3:0] g, input logic [1:0] ix, input logic b);
      check({tag, ".grant"}, 32'(arb_if.o_grant), 32'(g));
      check({tag, ".index"}, 32'(arb_if.o_grant_index), 32'(ix));
      check({tag, ".busy"}, 32'(arb_if.o_busy), 32'(b));
   endtask

   // Advance past the next rising edge so outputs are stable for sampling/driving.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic release_grant(input string tag);
      arb_if.i_done = 1'b1;
      tick();
      arb_if.i_done = 1'b0;
      check_arb({tag, ".rel"}, 4'b0000, 2'd0, 1'b0);
   endtask

   initial begin
      checks           = 0;
      errors           = 0;
      rst_n            = 1'b0;
      arb_if.i_request = '0;
      arb_if.i_done    = 1'b0;
      #2;
      check_arb("reset", 4'b0000, 2'd0, 1'b0);
      check("reset.timeout", 32'(arb_if.o_timeout), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();

      // Fairness: all requesting, grants rotate 0,1,2,3,0.
      arb_if.i_request = 4'b1111;
      for (int g = 0; g < 5; g++) begin
         tick();
         check_arb($sformatf("fair%0d", g), 4'(1 << (g % 4)), 2'(g % 4), 1'b1);
         tick();
         check_arb($sformatf("fair%0d.hold", g), 4'(1 << (g % 4)), 2'(g % 4), 1'b1);
         release_grant($sformatf("fair%0d", g));
      end
      arb_if.i_request = '0;
      tick();

      // Latency and hold: grant 2 held after its request drops, released by done.
      arb_if.i_request = 4'b0100;
      tick();
      check_arb("lat", 4'b0100, 2'd2, 1'b1);
      tick();
      arb_if.i_request = 4'b0000;
      tick();
      check_arb("hold1", 4'b0100, 2'd2, 1'b1);
      tick();
      check_arb("hold2", 4'b0100, 2'd2, 1'b1);
      release_grant("hold");

      // Wrap: pointer 3, requests 0 and 1 -> 0 then 1.
      arb_if.i_request = 4'b0011;
      tick();
      check_arb("wrap0", 4'b0001, 2'd0, 1'b1);
      release_grant("wrap0");
      tick();
      check_arb("wrap1", 4'b0010, 2'd1, 1'b1);
      release_grant("wrap1");
      arb_if.i_request = '0;
      tick();

      // Mid-BUSY asynchronous reset drops grant 2 without a clock edge.
      arb_if.i_request = 4'b0100;
      tick();
      check_arb("pre_rst", 4'b0100, 2'd2, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check_arb("async_rst", 4'b0000, 2'd0, 1'b0);
      arb_if.i_request = '0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // Done in IDLE is ignored; pointer back at 0 so bit 0 wins over 2 and 3.
      for (int k = 0; k < 3; k++) begin
         arb_if.i_done = 1'b1;
         tick();
         check_arb($sformatf("idle_done%0d", k), 4'b0000, 2'd0, 1'b0);
      end
      arb_if.i_done    = 1'b0;
      arb_if.i_request = 4'b1101;
      tick();
      check_arb("after_rst", 4'b0001, 2'd0, 1'b1);
      release_grant("after_rst");
      arb_if.i_request = 4'b1100;
      tick();
      check_arb("req1100", 4'b0100, 2'd2, 1'b1);
      release_grant("req1100");
      arb_if.i_request = '0;
      tick();

      // Timeout behaviour: grant 0 with no done.
      arb_if.i_request = 4'b0001;
      tick();
      check_arb("to_grant", 4'b0001, 2'd0, 1'b1);
      arb_if.i_request = '0;
`ifdef RGGEN_RR_ARBITER_TIMEOUT_EN
      for (int c = 1; c <= 8; c++) begin
         tick();
         check_arb($sformatf("to_busy%0d", c), 4'b0001, 2'd0, 1'b1);
         check($sformatf("to_nopulse%0d", c), 32'(arb_if.o_timeout), 32'd0);
      end
      tick();
      check_arb("to_release", 4'b0000, 2'd0, 1'b0);
      check("to_pulse", 32'(arb_if.o_timeout), 32'd1);
      tick();
      check("to_pulse_end", 32'(arb_if.o_timeout), 32'd0);
`else
      for (int c = 1; c <= 110; c++) begin
         tick();
         check($sformatf("nt_timeout%0d", c), 32'(arb_if.o_timeout), 32'd0);
      end
      check_arb("nt_held", 4'b0001, 2'd0, 1'b1);
      release_grant("nt");
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/rggen_rr_arbiter.md
RGGEN_RR_ARBITER -- requirements
Module: rggen_rr_arbiter

Interface
REQ-001 SHALL have parameter REQUESTERS, default 2, meaning number of requesters sharing the resource (legal range 1 to 32).
REQ-002 SHALL have parameter TIMEOUT, default 255, meaning the maximum number of BUSY cycles before a forced release (legal range 1 to 65535).
REQ-003 SHALL have port i_clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_rst_n, input, 1 bit, reset; asynchronous assertion, active-low.
REQ-005 SHALL have port i_request, input, REQUESTERS bits; bit i set means requester i wants the resource.
REQ-006 SHALL have port i_done, input, 1 bit; the shared resource finished the current grantee's transfer.
REQ-007 SHALL have port o_grant, output, REQUESTERS bits; one-hot or zero, drives the select input of the shared mux directly.
REQ-008 SHALL have port o_grant_index, output, max(1,$clog2(REQUESTERS)) bits; binary index of the current grantee, 0 when no grant.
REQ-009 SHALL have port o_busy, output, 1 bit; high while any grant is held.
REQ-010 SHALL have port o_timeout, output, 1 bit; single-cycle pulse on a forced release.

Function
REQ-011 SHALL implement two states: IDLE (o_grant zero) and BUSY (exactly one o_grant bit set).
REQ-012 SHALL maintain a priority pointer; in IDLE, on the edge where i_request is non-zero, the winner is the first set bit at or above the pointer, wrapping from REQUESTERS-1 to 0.
REQ-013 SHALL register the grant: a request seen at edge k in IDLE gives o_grant, o_grant_index and o_busy at edge k+1 (1-cycle latency), with the state set to BUSY.
REQ-014 SHALL hold o_grant constant throughout BUSY regardless of i_request changes, including the grantee dropping its request.
REQ-015 SHALL, on an edge in BUSY with i_done high, clear o_grant and o_busy, set the pointer to (winner+1) mod REQUESTERS, and return to IDLE.
REQ-016 SHALL spend at least one IDLE cycle between consecutive grants; back-to-back grants are spaced 1 idle cycle apart.
REQ-017 SHALL ignore i_done while in IDLE; the pointer and state do not change.
REQ-018 SHALL, with REQUESTERS=1, keep the pointer at 0 and grant bit 0 whenever i_request[0] is set in IDLE.
REQ-019 SHALL keep o_grant and o_grant_index consistent at all times; o_grant is never multi-hot.

Reset
REQ-020 SHALL, while i_rst_n is low, force state IDLE, pointer 0, o_grant 0, o_grant_index 0, o_busy 0, o_timeout 0 and the timeout counter to 0, immediately and independent of i_clk.
REQ-021 SHALL, on reset asserted mid-BUSY, drop the grant immediately and resume arbitration from pointer 0 after release.

Configuration
REQ-022 SHALL honour macro RGGEN_RR_ARBITER_TIMEOUT_EN.
- Defined: a 16-bit counter clears on entry to BUSY and increments each BUSY cycle without i_done. When it reaches TIMEOUT, the next edge releases the grant exactly as REQ-015 and pulses o_timeout high for one cycle. If i_done occurs on that same edge, i_done wins and no pulse is raised.
- Undefined: no counter is built, o_timeout is tied to 0, and a grant is held until i_done.

Verification
REQ-023 SHALL cover fairness: REQUESTERS=4, i_request=4'b1111 held, i_done pulsed 2 cycles after each grant -> grant sequence 0,1,2,3,0 with o_grant_index 0,1,2,3,0.
REQ-024 SHALL cover wrap-around: pointer 3 (after grant 2), i_request=4'b0011 -> grant 0, then grant 1.
REQ-025 SHALL cover latency and hold: i_request=4'b0100 at edge k -> o_grant=4'b0100 at k+1; request dropped at k+2 -> grant held until i_done, cleared on the i_done edge.
REQ-026 SHALL cover timeout: with macro defined and TIMEOUT=8, grant with no i_done -> release and 1-cycle o_timeout pulse after 8 BUSY cycles. With macro undefined, the grant persists beyond 100 cycles and o_timeout stays 0.
REQ-027 SHALL cover mid-operation reset: i_rst_n low during BUSY grant 2 -> o_grant=0 without a clock edge. After release, with i_request=4'b1100, the next grant is 2.
REQ-028 SHALL cover the ignored-done case: i_done pulsed in IDLE with i_request=0 -> pointer unchanged, and the next request from bit 0 is granted first.
